// File: rtl/im_port_arbiter.sv
// Shares a single-port instruction memory between the CPU fetch port (fixed priority)
// and a loader/debug port, with a starvation escape that forces one loader grant.
module im_port_arbiter #(
  parameter int AW         = 7,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          f_req,
  input  logic [31:0]   f_addr,
  output logic          f_gnt,
  output logic          f_rvalid,
  output logic [DW-1:0] f_rdata,
  input  logic          l_req,
  input  logic          l_we,
  input  logic [31:0]   l_addr,
  input  logic [DW-1:0] l_wdata,
  output logic          l_gnt,
  output logic          l_rvalid,
  output logic [DW-1:0] l_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int CW = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(STARVE_MAX - 1);

  typedef enum logic {NORMAL, FORCE} state_t;

  state_t          state;
  logic [CW-1:0]   starve_cnt;
  logic            rd_pend;
  logic            rd_owner;
  logic [DW-1:0]   f_rdata_q;
  logic [DW-1:0]   l_rdata_q;
  logic            f_win;
  logic            l_win;
  logic            unused_addr_bits;

  // Grant decision: requests are ignored entirely while reset is asserted.
  always_comb begin
    f_win = 1'b0;
    l_win = 1'b0;
    if (rst_n) begin
      if (state == FORCE) begin
        if (l_req)      l_win = 1'b1;
        else if (f_req) f_win = 1'b1;
      end else begin
        if (f_req)      f_win = 1'b1;
        else if (l_req) l_win = 1'b1;
      end
    end
  end

  assign f_gnt     = f_win;
  assign l_gnt     = l_win;
  assign mem_en    = f_win | l_win;
  assign mem_we    = l_win & l_we;
  assign mem_addr  = l_win ? l_addr[AW+1:2] : (f_win ? f_addr[AW+1:2] : '0);
  assign mem_wdata = (l_win & l_we) ? l_wdata : '0;

  // Read return stage: data comes straight from memory the cycle after the grant,
  // otherwise each port holds the last word it was handed.
  assign f_rvalid = rst_n & rd_pend & ~rd_owner;
  assign l_rvalid = rst_n & rd_pend & rd_owner;
  assign f_rdata  = f_rvalid ? mem_rdata : f_rdata_q;
  assign l_rdata  = l_rvalid ? mem_rdata : l_rdata_q;

  assign unused_addr_bits = ^{f_addr[31:AW+2], f_addr[1:0], l_addr[31:AW+2], l_addr[1:0]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= NORMAL;
      starve_cnt <= '0;
      rd_pend    <= 1'b0;
      rd_owner   <= 1'b0;
      f_rdata_q  <= '0;
      l_rdata_q  <= '0;
    end else begin
      rd_pend  <= f_win | (l_win & ~l_we);
      rd_owner <= l_win;
      if (f_rvalid) f_rdata_q <= mem_rdata;
      if (l_rvalid) l_rdata_q <= mem_rdata;
      case (state)
        NORMAL: begin
          if (l_req && !l_win) begin
            if (starve_cnt == CNT_TOP) state <= FORCE;
            else                       starve_cnt <= starve_cnt + 1'b1;
          end else begin
            starve_cnt <= '0;
          end
        end
        FORCE: begin
          // Either the loader took its forced slot or it stopped asking.
          state      <= NORMAL;
          starve_cnt <= '0;
        end
        default: begin
          state      <= NORMAL;
          starve_cnt <= '0;
        end
      endcase
    end
  end

endmodule
